// File: rtl/decoder_sdiv_26s_10s_16_seq_if.sv
// Operand/result handshake bundle for the decoder's iterative signed divider.
interface decoder_sdiv_26s_10s_16_seq_if #(
  parameter int unsigned din0_WIDTH = 26,
  parameter int unsigned din1_WIDTH = 10,
  parameter int unsigned dout_WIDTH = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic                  out_valid;
  logic                  out_ready;
  logic [dout_WIDTH-1:0] dout;
  logic [din1_WIDTH-1:0] rem_out;
  logic                  overflow;
  logic                  div_by_zero;

  modport master (
    output in_valid, din0, din1, out_ready,
    input  in_ready, out_valid, dout, rem_out, overflow, div_by_zero
  );

  modport slave (
    input  in_valid, din0, din1, out_ready,
    output in_ready, out_valid, dout, rem_out, overflow, div_by_zero
  );
endinterface

// File: rtl/decoder_sdiv_26s_10s_16_seq.sv
// Iterative signed restoring divider: 26s / 10s -> saturated 16s quotient plus remainder,
// one quotient bit per cycle, fixed latency, single operation in flight.
module decoder_sdiv_26s_10s_16_seq #(
  parameter int unsigned din0_WIDTH = 26,
  parameter int unsigned din1_WIDTH = 10,
  parameter int unsigned dout_WIDTH = 16
) (
  input  logic                           ap_clk,
  input  logic                           ap_rst,
  decoder_sdiv_26s_10s_16_seq_if.slave   bus
);
  localparam int unsigned CNT_W = $clog2(din0_WIDTH + 1);
  localparam int unsigned TRY_W = din1_WIDTH + 1;

  localparam logic [dout_WIDTH-1:0] DOUT_MAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
  localparam logic [dout_WIDTH-1:0] DOUT_MIN = {1'b1, {(dout_WIDTH-1){1'b0}}};
  localparam logic [din0_WIDTH-1:0] POS_LIM  = din0_WIDTH'(DOUT_MAX);
  localparam logic [din0_WIDTH-1:0] NEG_LIM  = din0_WIDTH'(DOUT_MIN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                state, state_nxt;
  logic [din0_WIDTH-1:0] qsh, qsh_nxt;     // dividend magnitude shifting out, quotient shifting in
  logic [din1_WIDTH-1:0] bmag, bmag_nxt;
  logic [din1_WIDTH-1:0] prem, prem_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  sign_a, sign_a_nxt;
  logic                  sign_b, sign_b_nxt;
  logic                  zdiv, zdiv_nxt;

  logic                  in_ready_q, in_ready_nxt;
  logic                  out_valid_q, out_valid_nxt;
  logic [dout_WIDTH-1:0] dout_q, dout_nxt;
  logic [din1_WIDTH-1:0] rem_q, rem_nxt;
  logic                  ovf_q, ovf_nxt;
  logic                  dbz_q, dbz_nxt;

  logic [TRY_W-1:0]      trial;
  logic                  trial_ge;
  logic                  neg_q;

  // State and datapath registers
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state       <= IDLE;
      qsh         <= '0;
      bmag        <= '0;
      prem        <= '0;
      cnt         <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      zdiv        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      rem_q       <= '0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state       <= state_nxt;
      qsh         <= qsh_nxt;
      bmag        <= bmag_nxt;
      prem        <= prem_nxt;
      cnt         <= cnt_nxt;
      sign_a      <= sign_a_nxt;
      sign_b      <= sign_b_nxt;
      zdiv        <= zdiv_nxt;
      in_ready_q  <= in_ready_nxt;
      out_valid_q <= out_valid_nxt;
      dout_q      <= dout_nxt;
      rem_q       <= rem_nxt;
      ovf_q       <= ovf_nxt;
      dbz_q       <= dbz_nxt;
    end
  end

  // Restoring step: shift next dividend bit into the partial remainder and trial-subtract
  assign trial    = {prem, qsh[din0_WIDTH-1]};
  assign trial_ge = (trial >= {1'b0, bmag});
  assign neg_q    = sign_a ^ sign_b;

  // Next-state and next-output logic
  always_comb begin
    state_nxt     = state;
    qsh_nxt       = qsh;
    bmag_nxt      = bmag;
    prem_nxt      = prem;
    cnt_nxt       = cnt;
    sign_a_nxt    = sign_a;
    sign_b_nxt    = sign_b;
    zdiv_nxt      = zdiv;
    in_ready_nxt  = in_ready_q;
    out_valid_nxt = out_valid_q;
    dout_nxt      = dout_q;
    rem_nxt       = rem_q;
    ovf_nxt       = ovf_q;
    dbz_nxt       = dbz_q;

    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          qsh_nxt      = bus.din0[din0_WIDTH-1] ? -bus.din0 : bus.din0;
          bmag_nxt     = bus.din1[din1_WIDTH-1] ? -bus.din1 : bus.din1;
          sign_a_nxt   = bus.din0[din0_WIDTH-1];
          sign_b_nxt   = bus.din1[din1_WIDTH-1];
          zdiv_nxt     = (bus.din1 == '0);
          prem_nxt     = '0;
          cnt_nxt      = CNT_W'(din0_WIDTH);
          in_ready_nxt = 1'b0;
          state_nxt    = CALC;
        end
      end

      CALC: begin
        prem_nxt = trial_ge ? din1_WIDTH'(trial - {1'b0, bmag}) : din1_WIDTH'(trial);
        qsh_nxt  = {qsh[din0_WIDTH-2:0], trial_ge};
        cnt_nxt  = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nxt = FIX;
        end
      end

      FIX: begin
        ovf_nxt = 1'b0;
        dbz_nxt = 1'b0;
        rem_nxt = sign_a ? -prem : prem;
        if (zdiv) begin
          dout_nxt = sign_a ? DOUT_MIN : DOUT_MAX;
          rem_nxt  = '0;
          dbz_nxt  = 1'b1;
        end else if (!neg_q && (qsh > POS_LIM)) begin
          dout_nxt = DOUT_MAX;
          ovf_nxt  = 1'b1;
        end else if (neg_q && (qsh > NEG_LIM)) begin
          dout_nxt = DOUT_MIN;
          ovf_nxt  = 1'b1;
        end else begin
          dout_nxt = neg_q ? dout_WIDTH'(-qsh) : dout_WIDTH'(qsh);
        end
        out_valid_nxt = 1'b1;
        state_nxt     = DONE;
      end

      DONE: begin
        if (bus.out_ready) begin
          out_valid_nxt = 1'b0;
          in_ready_nxt  = 1'b1;
          state_nxt     = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.dout        = dout_q;
  assign bus.rem_out     = rem_q;
  assign bus.overflow    = ovf_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_decoder_sdiv_26s_10s_16_seq.sv
// Directed bench for the signed divider: expected results come from a native-integer model
// pushed to a scoreboard at issue time and popped when the result handshake appears.
module tb_decoder_sdiv_26s_10s_16_seq;
  localparam int unsigned LAT = 27;

  typedef struct {
    logic [15:0] dout;
    logic [9:0]  rem;
    logic        ovf;
    logic        dbz;
  } exp_t;

  logic clk;
  logic ap_rst;
  int   n_assert;
  int   n_fail;
  exp_t sb[$];

  decoder_sdiv_26s_10s_16_seq_if bus ();

  decoder_sdiv_26s_10s_16_seq dut (
    .ap_clk (clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int a, input int b);
    exp_t e;
    int   q;
    e.ovf = 1'b0;
    e.dbz = 1'b0;
    if (b == 0) begin
      e.dout = (a < 0) ? 16'h8000 : 16'h7fff;
      e.rem  = '0;
      e.dbz  = 1'b1;
    end else begin
      q     = a / b;
      e.rem = 10'(a % b);
      if (q > 32767) begin
        e.dout = 16'h7fff;
        e.ovf  = 1'b1;
      end else if (q < -32768) begin
        e.dout = 16'h8000;
        e.ovf  = 1'b1;
      end else begin
        e.dout = 16'(q);
      end
    end
    return e;
  endfunction

  // Drive operands for one accept edge, push the model result
  task automatic issue(input int a, input int b);
    check("in_ready_before_issue", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.din0     = 26'(a);
    bus.din1     = 10'(b);
    sb.push_back(model(a, b));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Bounded wait for out_valid; lat is cycles after the accept edge
  task automatic wait_out(output int lat);
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      if (lat == 0) begin
        @(posedge clk);
        #1;
        if (bus.out_valid) lat = i;
      end
    end
    if (lat == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL out_valid_timeout: observed none expected within 100 cycles");
    end
  endtask

  task automatic pop_check(input string tag, output exp_t e);
    check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_dout"}, 32'(bus.dout), 32'(e.dout));
      check({tag, "_rem"},  32'(bus.rem_out), 32'(e.rem));
      check({tag, "_ovf"},  32'(bus.overflow), 32'(e.ovf));
      check({tag, "_dbz"},  32'(bus.div_by_zero), 32'(e.dbz));
    end
  endtask

  task automatic run_op(input string tag, input int a, input int b);
    int   lat;
    exp_t e;
    issue(a, b);
    wait_out(lat);
    check({tag, "_latency"}, 32'(lat), 32'(LAT));
    pop_check(tag, e);
    @(posedge clk);
    #1;
    check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int   lat;
    int   seen;
    exp_t cur;
    n_assert      = 0;
    n_fail        = 0;
    ap_rst        = 1'b1;
    bus.in_valid  = 1'b0;
    bus.din0      = '0;
    bus.din1      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ap_rst = 1'b0;

    check("rst_in_ready",  32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_dout",      32'(bus.dout), 32'd0);
    check("rst_rem",       32'(bus.rem_out), 32'd0);
    check("rst_flags",     32'({bus.overflow, bus.div_by_zero}), 32'd0);

    run_op("pos_pos", 1000, 7);
    check("pos_pos_dout_const", 32'(bus.dout), 32'd142);
    run_op("neg_pos", -1000, 7);
    run_op("pos_neg", 1000, -7);
    run_op("neg_neg", -1000, -7);
    run_op("sat_pos", 16777216, 1);
    run_op("sat_minmin", -33554432, -1);
    run_op("edge_min", -32768, 1);
    run_op("sat_m512", -33554432, -512);
    run_op("dbz_neg", -5, 0);
    run_op("dbz_pos", 5, 0);
    run_op("exact", 511, -511);

    // Backpressure: hold the result while in_valid pulses are ignored
    bus.out_ready = 1'b0;
    issue(-12345, 100);
    wait_out(lat);
    check("bp_latency", 32'(lat), 32'(LAT));
    pop_check("bp", cur);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.din0     = 26'(777 + i);
      bus.din1     = 10'(3);
      @(posedge clk);
      #1;
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      check("bp_hold_ready", 32'(bus.in_ready), 32'd0);
      check("bp_hold_dout",  32'(bus.dout), 32'(cur.dout));
      check("bp_hold_rem",   32'(bus.rem_out), 32'(cur.rem));
      check("bp_hold_flags", 32'({bus.overflow, bus.div_by_zero}), 32'({cur.ovf, cur.dbz}));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 32'(bus.out_valid), 32'd0);
    check("bp_release_ready", 32'(bus.in_ready), 32'd1);
    run_op("b2b", 300000, 37);

    // Reset ten cycles into CALC discards the operation
    issue(1000, 7);
    repeat (9) @(posedge clk);
    #1;
    ap_rst = 1'b1;
    @(posedge clk);
    #1;
    ap_rst = 1'b0;
    if (sb.size() != 0) void'(sb.pop_back());
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready",  32'(bus.in_ready), 32'd1);
    check("midrst_dout",      32'(bus.dout), 32'd0);
    check("midrst_rem",       32'(bus.rem_out), 32'd0);
    check("midrst_flags",     32'({bus.overflow, bus.div_by_zero}), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check("midrst_no_result", 32'(seen), 32'd0);
    run_op("fresh", 100, 3);
    check("fresh_dout_const", 32'(bus.dout), 32'd33);
    check("fresh_rem_const",  32'(bus.rem_out), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
